// File: rtl/mux_3b_pkg.sv
// -----------------------------------------------------------------------------
// mux_3b_pkg
// Shared constants for the mux_3b selector.
//   W_ENTRADA1_DEF / W_ENTRADA2_DEF : default operand widths (narrow / wide)
//   SEL_ENTRADA1 / SEL_ENTRADA2     : SinalControle encodings
//   widths_legal()                  : parameter legality predicate used by the top
// -----------------------------------------------------------------------------
package mux_3b_pkg;

  localparam int W_ENTRADA1_DEF = 2;
  localparam int W_ENTRADA2_DEF = 3;

  localparam logic SEL_ENTRADA1 = 1'b0;
  localparam logic SEL_ENTRADA2 = 1'b1;

  // The narrow operand must be non-empty and no wider than the result.
  function automatic bit widths_legal(input int w_narrow, input int w_wide);
    return (w_narrow >= 1) && (w_narrow <= w_wide);
  endfunction

endpackage

// File: rtl/mux_3b_ext.sv
// -----------------------------------------------------------------------------
// mux_3b_ext
// Widens the narrow operand from W_IN to W_OUT bits.
// Build option: MUX3B_SIGN_EXT_EN
//   undefined (default) : zero-extension
//   defined             : sign-extension from din[W_IN-1]
// Ports:
//   din  in  [W_IN-1:0]  : narrow operand
//   dout out [W_OUT-1:0] : extended operand
// -----------------------------------------------------------------------------
module mux_3b_ext #(
  parameter int W_IN  = 2,
  parameter int W_OUT = 3
) (
  input  logic [W_IN-1:0]  din,
  output logic [W_OUT-1:0] dout
);

  // Equal widths need their own branch: a zero-count replication is illegal.
  generate
    if (W_OUT == W_IN) begin : g_same
      assign dout = din;
    end else begin : g_ext
`ifdef MUX3B_SIGN_EXT_EN
      assign dout = {{(W_OUT-W_IN){din[W_IN-1]}}, din};
`else
      assign dout = {{(W_OUT-W_IN){1'b0}}, din};
`endif
    end
  endgenerate

endmodule

// File: rtl/mux_3b.sv
// -----------------------------------------------------------------------------
// mux_3b
// Registered two-way selector: narrow operand (extended) or wide operand.
// Build option: MUX3B_SIGN_EXT_EN (sign- instead of zero-extension of Entrada1,
// handled inside mux_3b_ext; affects SaidaDireta and Saida identically).
// Ports:
//   Clock         in  1           : rising-edge clock
//   Reset         in  1           : synchronous, active-high reset
//   Entrada1      in  W_ENTRADA1  : narrow operand
//   Entrada2      in  W_ENTRADA2  : wide operand
//   SinalControle in  1           : 0 -> extended Entrada1, 1 -> Entrada2
//   EntradaValida in  1           : qualifies inputs for capture
//   SaidaDireta   out W_ENTRADA2  : combinational selection
//   Saida         out W_ENTRADA2  : registered selection
//   SaidaValida   out 1           : Saida loaded from a valid input last edge
//
// Handshake: valid-only, no ready. Every edge with EntradaValida=1 (and no
// Reset) is a transfer; the result appears on Saida with SaidaValida=1 one
// edge later. The consumer cannot stall, so back-to-back inputs give
// back-to-back outputs. With EntradaValida=0, Saida holds and SaidaValida=0.
// -----------------------------------------------------------------------------
module mux_3b
  import mux_3b_pkg::*;
#(
  parameter int W_ENTRADA1 = W_ENTRADA1_DEF,
  parameter int W_ENTRADA2 = W_ENTRADA2_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [W_ENTRADA1-1:0] Entrada1,
  input  logic [W_ENTRADA2-1:0] Entrada2,
  input  logic                  SinalControle,
  input  logic                  EntradaValida,
  output logic [W_ENTRADA2-1:0] SaidaDireta,
  output logic [W_ENTRADA2-1:0] Saida,
  output logic                  SaidaValida
);

  generate
    if (!widths_legal(W_ENTRADA1, W_ENTRADA2)) begin : g_bad_params
      $error("mux_3b: W_ENTRADA1 must satisfy 1 <= W_ENTRADA1 <= W_ENTRADA2");
    end
  endgenerate

  logic [W_ENTRADA2-1:0] entrada1_ext;

  mux_3b_ext #(
    .W_IN  (W_ENTRADA1),
    .W_OUT (W_ENTRADA2)
  ) u_ext (
    .din  (Entrada1),
    .dout (entrada1_ext)
  );

  always_comb begin
    SaidaDireta = Entrada2;
    case (SinalControle)
      SEL_ENTRADA1: SaidaDireta = entrada1_ext;
      default:      SaidaDireta = Entrada2;
    endcase
  end

  // Reset wins over a simultaneous valid input: that capture is discarded.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Saida       <= '0;
      SaidaValida <= 1'b0;
    end else begin
      SaidaValida <= EntradaValida;
      if (EntradaValida) begin
        Saida <= SaidaDireta;
      end
    end
  end

endmodule

// File: tb/tb_mux_3b.sv
// -----------------------------------------------------------------------------
// tb_mux_3b
// Directed plus short random stimulus for mux_3b with an expected-value queue.
// -----------------------------------------------------------------------------
module tb_mux_3b;

  localparam int W1 = 2;
  localparam int W2 = 3;

  // ---------------- clock / reset ----------------
  logic          Clock;
  logic          Reset;
  logic [W1-1:0] Entrada1;
  logic [W2-1:0] Entrada2;
  logic          SinalControle;
  logic          EntradaValida;
  logic [W2-1:0] SaidaDireta;
  logic [W2-1:0] Saida;
  logic          SaidaValida;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  mux_3b #(
    .W_ENTRADA1 (W1),
    .W_ENTRADA2 (W2)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .Entrada1      (Entrada1),
    .Entrada2      (Entrada2),
    .SinalControle (SinalControle),
    .EntradaValida (EntradaValida),
    .SaidaDireta   (SaidaDireta),
    .Saida         (Saida),
    .SaidaValida   (SaidaValida)
  );

  // ---------------- scoreboard ----------------
  logic [W2-1:0] exp_q[$];
  logic [W2-1:0] exp_saida;
  logic          exp_valid;
  int            tests;
  int            fails;

  function automatic logic [W2-1:0] model(input logic [W1-1:0] e1,
                                          input logic [W2-1:0] e2,
                                          input logic          sel);
    logic [W2-1:0] ext;
`ifdef MUX3B_SIGN_EXT_EN
    ext = {e1[W1-1], e1};
`else
    ext = {1'b0, e1};
`endif
    return sel ? e2 : ext;
  endfunction

  task automatic check(input string tag, input logic [W2-1:0] obs,
                       input logic [W2-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs right after an edge, checks the combinational
  // path, then crosses the next rising edge and checks the registered outputs.
  task automatic step(input string tag, input logic [W1-1:0] e1,
                      input logic [W2-1:0] e2, input logic sel,
                      input logic vld, input logic rst);
    logic [W2-1:0] d;
    Entrada1      = e1;
    Entrada2      = e2;
    SinalControle = sel;
    EntradaValida = vld;
    Reset         = rst;
    #1;
    d = model(e1, e2, sel);
    check({tag, "_direta"}, SaidaDireta, d);
    if (vld && !rst) exp_q.push_back(d);
    @(posedge Clock);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_saida = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = vld;
    end
    check({tag, "_valida"}, {2'b00, SaidaValida}, {2'b00, exp_valid});
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s_queue observed=empty expected=entry", tag);
      end else begin
        exp_saida = exp_q.pop_front();
      end
    end
    check({tag, "_saida"}, Saida, exp_saida);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W1-1:0] r1;
    logic [W2-1:0] r2;
    logic          rs;
    logic          rv;
    tests = 0;
    fails = 0;
    exp_saida = '0;
    exp_valid = 1'b0;
    Reset = 1'b1;
    Entrada1 = '0;
    Entrada2 = '0;
    SinalControle = 1'b0;
    EntradaValida = 1'b0;

    @(posedge Clock);
    #1;
    check("reset_saida", Saida, 3'b000);
    check("reset_valida", {2'b00, SaidaValida}, 3'b000);
    step("reset_hold", 2'b11, 3'b111, 1'b1, 1'b1, 1'b1);

    // Zero-extend and wide paths
    step("narrow", 2'b10, 3'b101, 1'b0, 1'b1, 1'b0);
    check("narrow_lit", Saida, model(2'b10, 3'b101, 1'b0));
    step("wide", 2'b10, 3'b101, 1'b1, 1'b1, 1'b0);
    check("wide_lit", Saida, 3'b101);

    // Reset mid-stream with a valid input on the same edge
    step("rst_mid", 2'b01, 3'b110, 1'b1, 1'b1, 1'b1);
    check("rst_mid_lit", Saida, 3'b000);
    step("rst_mid2", 2'b01, 3'b110, 1'b0, 1'b1, 1'b1);

    // Hold with EntradaValida=0
    step("load", 2'b00, 3'b101, 1'b1, 1'b1, 1'b0);
    step("hold", 2'b00, 3'b011, 1'b1, 1'b0, 1'b0);
    check("hold_lit", Saida, 3'b101);
    step("hold2", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0);

    // Extension direction of the narrow operand
    step("ext_msb1", 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    step("ext_msb0", 2'b01, 3'b111, 1'b0, 1'b1, 1'b0);
    check("ext_msb0_lit", Saida, 3'b001);

    // Inputs wiggle between edges; only the final values are captured
    Entrada2 = 3'b010;
    SinalControle = 1'b1;
    EntradaValida = 1'b1;
    #2;
    step("glitch", 2'b11, 3'b110, 1'b1, 1'b1, 1'b0);

    // Streaming, alternating select
    for (int i = 0; i < 6; i++) begin
      step("stream", 2'b11, 3'b100, i[0], 1'b1, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      r1 = W1'($urandom_range(0, 3));
      r2 = W2'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      step("rand", r1, r2, rs, rv, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
